// File: rtl/cdc_sched_pkg.sv
// Shared types and elaboration-time helpers for the fast-to-slow transfer scheduler.
package cdc_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_HOLDOFF
    } sched_state_t;

    function automatic int calc_tag_w(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

    // Three slow periods cover the pulse extender plus the two-flop synchronizer, with margin.
    function automatic int calc_holdoff(input int fast_freq, input int slow_freq);
        return 3 * (fast_freq / slow_freq) + 4;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first asserted request at or above ptr, wrapping.
module rr_arbiter #(
    parameter int NUM_CH = 2,
    parameter int TAG_W  = 1
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [TAG_W-1:0]  ptr,
    output logic [NUM_CH-1:0] grant,
    output logic [TAG_W-1:0]  idx
);

    logic found;
    int   cand;

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        cand  = 0;
        for (int off = 0; off < NUM_CH; off++) begin
            cand = (int'(ptr) + off) % NUM_CH;
            if (!found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                idx         = TAG_W'(cand);
            end
        end
    end

endmodule

// File: rtl/cdc_xfer_scheduler.sv
// Round-robin scheduler feeding one shared fast-to-slow data crossing, with a post-transfer hold-off.
// Optional macro CDC_SCHED_OVERRUN_EN: a write to a full slot overwrites it and sets a sticky Overrun bit.
module cdc_xfer_scheduler
    import cdc_sched_pkg::*;
#(
    parameter int  WIDTH          = 16,
    parameter int  NUM_CH         = 2,
    parameter int  FAST_FREQ      = 100,
    parameter int  SLOW_FREQ      = 12,
    localparam int TAG_W          = calc_tag_w(NUM_CH),
    localparam int HOLDOFF_CYCLES = calc_holdoff(FAST_FREQ, SLOW_FREQ)
) (
    input  logic                    Clk,
    input  logic                    Rst,
    input  logic [NUM_CH-1:0]       Req_Valid,
    input  logic [NUM_CH*WIDTH-1:0] Req_Data,
    output logic [NUM_CH-1:0]       Req_Ready,
    output logic [TAG_W+WIDTH-1:0]  Xfer_Word,
    output logic                    Xfer_Valid,
    output logic [NUM_CH-1:0]       Overrun,
    input  logic                    Ovr_Clr
);

    localparam int CNT_W = $clog2(HOLDOFF_CYCLES);

    sched_state_t              state_q, state_d;
    logic [TAG_W-1:0]          rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [TAG_W+WIDTH-1:0]    xfer_word_q, xfer_word_d;
    logic                      xfer_valid_q, xfer_valid_d;

    logic [NUM_CH-1:0]         full_vec;
    logic [WIDTH-1:0]          slot_data [NUM_CH];
    logic [NUM_CH-1:0]         arb_grant;
    logic [TAG_W-1:0]          arb_idx;
    logic [NUM_CH-1:0]         grant;

    rr_arbiter #(
        .NUM_CH (NUM_CH),
        .TAG_W  (TAG_W)
    ) u_arb (
        .req   (full_vec),
        .ptr   (rr_ptr_q),
        .grant (arb_grant),
        .idx   (arb_idx)
    );

    // Grants are only honoured while the crossing is free.
    assign grant = (state_q == ST_IDLE) ? arb_grant : '0;

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : gen_ch
            logic [WIDTH-1:0] data_q, data_d;
            logic             full_q, full_d;

            assign Req_Ready[gi] = !full_q | grant[gi];
            assign full_vec[gi]  = full_q;
            assign slot_data[gi] = data_q;

`ifdef CDC_SCHED_OVERRUN_EN
            logic ovr_q, ovr_d;

            always_comb begin
                data_d = data_q;
                full_d = full_q;
                ovr_d  = ovr_q;
                if (grant[gi]) begin
                    full_d = 1'b0;
                end
                if (Req_Valid[gi]) begin
                    data_d = Req_Data[gi*WIDTH +: WIDTH];
                    full_d = 1'b1;
                    if (!Req_Ready[gi]) begin
                        ovr_d = 1'b1;
                    end
                end
                if (Ovr_Clr) begin
                    ovr_d = 1'b0;
                end
            end

            always_ff @(posedge Clk) begin
                if (Rst) begin
                    ovr_q <= 1'b0;
                end else begin
                    ovr_q <= ovr_d;
                end
            end

            assign Overrun[gi] = ovr_q;
`else
            always_comb begin
                data_d = data_q;
                full_d = full_q;
                if (grant[gi]) begin
                    full_d = 1'b0;
                end
                // A write into a full, ungranted slot is dropped.
                if (Req_Valid[gi] && Req_Ready[gi]) begin
                    data_d = Req_Data[gi*WIDTH +: WIDTH];
                    full_d = 1'b1;
                end
            end

            assign Overrun[gi] = 1'b0;
`endif

            always_ff @(posedge Clk) begin
                if (Rst) begin
                    data_q <= '0;
                    full_q <= 1'b0;
                end else begin
                    data_q <= data_d;
                    full_q <= full_d;
                end
            end
        end
    endgenerate

`ifndef CDC_SCHED_OVERRUN_EN
    logic unused_ovr_clr;
    assign unused_ovr_clr = Ovr_Clr;
`endif

    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        cnt_d        = cnt_q;
        xfer_word_d  = xfer_word_q;
        xfer_valid_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (|full_vec) begin
                    state_d     = ST_ISSUE;
                    xfer_word_d = {arb_idx, slot_data[arb_idx]};
                    rr_ptr_d    = (arb_idx == TAG_W'(NUM_CH - 1)) ? '0 : arb_idx + 1'b1;
                end
            end
            ST_ISSUE: begin
                xfer_valid_d = 1'b1;
                cnt_d        = CNT_W'(HOLDOFF_CYCLES - 1);
                state_d      = ST_HOLDOFF;
            end
            ST_HOLDOFF: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q      <= ST_IDLE;
            rr_ptr_q     <= '0;
            cnt_q        <= '0;
            xfer_word_q  <= '0;
            xfer_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            cnt_q        <= cnt_d;
            xfer_word_q  <= xfer_word_d;
            xfer_valid_q <= xfer_valid_d;
        end
    end

    assign Xfer_Word  = xfer_word_q;
    assign Xfer_Valid = xfer_valid_q;

endmodule

// File: tb/tb_cdc_xfer_scheduler.sv
// Directed self-checking bench for cdc_xfer_scheduler at default parameters (2 channels, 28-cycle hold-off).
module tb_cdc_xfer_scheduler;

    logic        Clk = 1'b0;
    logic        Rst = 1'b1;
    logic [1:0]  Req_Valid = '0;
    logic [31:0] Req_Data = '0;
    logic [1:0]  Req_Ready;
    logic [16:0] Xfer_Word;
    logic        Xfer_Valid;
    logic [1:0]  Overrun;
    logic        Ovr_Clr = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    typedef struct {
        int          cyc;
        logic [16:0] word;
    } pulse_t;
    pulse_t pulses[$];

    cdc_xfer_scheduler dut (
        .Clk        (Clk),
        .Rst        (Rst),
        .Req_Valid  (Req_Valid),
        .Req_Data   (Req_Data),
        .Req_Ready  (Req_Ready),
        .Xfer_Word  (Xfer_Word),
        .Xfer_Valid (Xfer_Valid),
        .Overrun    (Overrun),
        .Ovr_Clr    (Ovr_Clr)
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk) cyc <= cyc + 1;

    always @(negedge Clk) begin
        if (Xfer_Valid === 1'b1) begin
            pulses.push_back('{cyc, Xfer_Word});
            $display("xfer: cyc=%0d tag=%0d data=0x%04h", cyc, Xfer_Word[16], Xfer_Word[15:0]);
        end
    end

    function automatic logic [16:0] pw(input int k);
        if (k < pulses.size()) return pulses[k].word;
        return 17'h1dead;
    endfunction

    function automatic int pc(input int k);
        if (k < pulses.size()) return pulses[k].cyc;
        return -1;
    endfunction

    task automatic do_reset();
        Req_Valid = '0;
        Ovr_Clr   = 1'b0;
        Rst       = 1'b1;
        repeat (3) @(negedge Clk);
        Rst = 1'b0;
        pulses.delete();
    endtask

    // Presents one sample per channel in v for one cycle; n is the accepting edge.
    task automatic drive(input logic [1:0] v, input logic [15:0] d0, input logic [15:0] d1, output int n);
        Req_Valid = v;
        Req_Data  = {d1, d0};
        n = cyc + 1;
        @(negedge Clk);
        Req_Valid = '0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if (Xfer_Valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", Xfer_Valid); end
        n_checks++;
        if (Xfer_Word !== 17'h0) begin n_fail++; $display("FAIL reset_word: got %h want 00000", Xfer_Word); end
        n_checks++;
        if (Req_Ready !== 2'b11) begin n_fail++; $display("FAIL reset_ready: got %b want 11", Req_Ready); end
        n_checks++;
        if (Overrun !== 2'b00) begin n_fail++; $display("FAIL reset_overrun: got %b want 00", Overrun); end
    endtask

    task automatic test_single();
        int n;
        do_reset();
        drive(2'b01, 16'h1234, 16'h0, n);
        repeat (40) @(negedge Clk);
        n_checks++;
        if (pulses.size() !== 1) begin n_fail++; $display("FAIL single_count: got %0d want 1", pulses.size()); end
        n_checks++;
        if (pc(0) !== n + 2) begin n_fail++; $display("FAIL single_latency: got cyc %0d want %0d", pc(0), n + 2); end
        n_checks++;
        if (pw(0) !== 17'h01234) begin n_fail++; $display("FAIL single_word: got %h want 01234", pw(0)); end
        n_checks++;
        if (Xfer_Word !== 17'h01234) begin n_fail++; $display("FAIL single_hold: got %h want 01234", Xfer_Word); end
    endtask

    task automatic test_simultaneous();
        int n;
        do_reset();
        drive(2'b11, 16'hAAAA, 16'h5555, n);
        repeat (70) @(negedge Clk);
        n_checks++;
        if (pulses.size() !== 2) begin n_fail++; $display("FAIL simul_count: got %0d want 2", pulses.size()); end
        n_checks++;
        if (pw(0) !== 17'h0AAAA) begin n_fail++; $display("FAIL simul_first: got %h want 0aaaa", pw(0)); end
        n_checks++;
        if (pw(1) !== 17'h15555) begin n_fail++; $display("FAIL simul_second: got %h want 15555", pw(1)); end
        n_checks++;
        if (pc(0) !== n + 2) begin n_fail++; $display("FAIL simul_t0: got %0d want %0d", pc(0), n + 2); end
        n_checks++;
        if (pc(1) - pc(0) !== 30) begin n_fail++; $display("FAIL simul_spacing: got %0d want 30", pc(1) - pc(0)); end
    endtask

    task automatic test_fairness();
        int n0, n;
        logic [16:0] exp_word;
        do_reset();
        n0 = cyc + 1;
        for (int r = 0; r < 3; r++) begin
            drive(2'b11, 16'h1000 + 16'(r), 16'h2000 + 16'(r), n);
            repeat (59) @(negedge Clk);
        end
        repeat (10) @(negedge Clk);
        n_checks++;
        if (pulses.size() !== 6) begin n_fail++; $display("FAIL fair_count: got %0d want 6", pulses.size()); end
        for (int k = 0; k < 6; k++) begin
            exp_word = (k % 2 == 0) ? {1'b0, 16'h1000 + 16'(k / 2)} : {1'b1, 16'h2000 + 16'(k / 2)};
            n_checks++;
            if (pw(k) !== exp_word) begin n_fail++; $display("FAIL fair_word[%0d]: got %h want %h", k, pw(k), exp_word); end
            n_checks++;
            if (pc(k) !== n0 + 2 + 30 * k) begin n_fail++; $display("FAIL fair_cyc[%0d]: got %0d want %0d", k, pc(k), n0 + 2 + 30 * k); end
        end
    endtask

    task automatic test_overrun();
        int m, n;
        logic [16:0] exp_word;
        logic [1:0]  exp_ovr;
`ifdef CDC_SCHED_OVERRUN_EN
        exp_word = 17'h00002;
        exp_ovr  = 2'b01;
`else
        exp_word = 17'h00001;
        exp_ovr  = 2'b00;
`endif
        do_reset();
        drive(2'b10, 16'h0, 16'h7777, m);
        repeat (2) @(negedge Clk);
        drive(2'b01, 16'h0001, 16'h0, n);
        n_checks++;
        if (Req_Ready[0] !== 1'b0) begin n_fail++; $display("FAIL ovr_ready_full: got %b want 0", Req_Ready[0]); end
        drive(2'b01, 16'h0002, 16'h0, n);
        n_checks++;
        if (Overrun !== exp_ovr) begin n_fail++; $display("FAIL ovr_flag: got %b want %b", Overrun, exp_ovr); end
        repeat (40) @(negedge Clk);
        n_checks++;
        if (pulses.size() !== 2) begin n_fail++; $display("FAIL ovr_count: got %0d want 2", pulses.size()); end
        n_checks++;
        if (pw(1) !== exp_word) begin n_fail++; $display("FAIL ovr_word: got %h want %h", pw(1), exp_word); end
        n_checks++;
        if (pc(1) !== m + 32) begin n_fail++; $display("FAIL ovr_cyc: got %0d want %0d", pc(1), m + 32); end
        n_checks++;
        if (Overrun !== exp_ovr) begin n_fail++; $display("FAIL ovr_sticky: got %b want %b", Overrun, exp_ovr); end
        Ovr_Clr = 1'b1;
        @(negedge Clk);
        Ovr_Clr = 1'b0;
        n_checks++;
        if (Overrun !== 2'b00) begin n_fail++; $display("FAIL ovr_clear: got %b want 00", Overrun); end
    endtask

    task automatic test_refill();
        int n, n2;
        do_reset();
        drive(2'b01, 16'h1111, 16'h0, n);
        n_checks++;
        if (Req_Ready[0] !== 1'b1) begin n_fail++; $display("FAIL refill_ready: got %b want 1", Req_Ready[0]); end
        drive(2'b01, 16'hBEEF, 16'h0, n2);
        repeat (40) @(negedge Clk);
        n_checks++;
        if (pulses.size() !== 2) begin n_fail++; $display("FAIL refill_count: got %0d want 2", pulses.size()); end
        n_checks++;
        if (pw(0) !== 17'h01111) begin n_fail++; $display("FAIL refill_first: got %h want 01111", pw(0)); end
        n_checks++;
        if (pw(1) !== 17'h0BEEF) begin n_fail++; $display("FAIL refill_second: got %h want 0beef", pw(1)); end
        n_checks++;
        if (pc(1) !== n + 32) begin n_fail++; $display("FAIL refill_cyc: got %0d want %0d", pc(1), n + 32); end
        n_checks++;
        if (Overrun !== 2'b00) begin n_fail++; $display("FAIL refill_overrun: got %b want 00", Overrun); end
    endtask

    task automatic test_reset_mid_holdoff();
        int n, p;
        do_reset();
        drive(2'b01, 16'h3333, 16'h0, n);
        repeat (2) @(negedge Clk);
        drive(2'b10, 16'h0, 16'h4444, p);
        repeat (5) @(negedge Clk);
        Rst = 1'b1;
        @(negedge Clk);
        Rst = 1'b0;
        n_checks++;
        if (Req_Ready !== 2'b11) begin n_fail++; $display("FAIL midrst_ready: got %b want 11", Req_Ready); end
        n_checks++;
        if (Xfer_Valid !== 1'b0) begin n_fail++; $display("FAIL midrst_valid: got %b want 0", Xfer_Valid); end
        repeat (40) @(negedge Clk);
        n_checks++;
        if (pulses.size() !== 1) begin n_fail++; $display("FAIL midrst_discard: got %0d pulses want 1", pulses.size()); end
        drive(2'b10, 16'h0, 16'h5678, p);
        repeat (3) @(negedge Clk);
        n_checks++;
        if (pc(1) !== p + 2) begin n_fail++; $display("FAIL midrst_latency: got cyc %0d want %0d", pc(1), p + 2); end
        n_checks++;
        if (pw(1) !== 17'h15678) begin n_fail++; $display("FAIL midrst_word: got %h want 15678", pw(1)); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_simultaneous();
        test_fairness();
        test_overrun();
        test_refill();
        test_reset_mid_holdoff();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cdc_xfer_scheduler.md
# cdc_xfer_scheduler

Schedules DSP output samples from several fast-domain producers onto a single shared Data_Fast_to_Slow crossing. It holds one pending sample per channel and grants the crossing round-robin. After each transfer it enforces a hold-off window, so a new Valid is never issued while the crossing's pulse extender and slow-side synchronizer are still busy. It sits in the fast domain, between the per-channel DSP outputs and the crossing's Data_In_Fast/Valid_In_Fast.

## Interface
- WIDTH, 16, sample width per channel
- NUM_CH, 2, number of producer channels (≥2)
- FAST_FREQ, 100, fast clock frequency (MHz)
- SLOW_FREQ, 12, slow clock frequency (MHz)
- TAG_W, derived: $clog2(NUM_CH)
- HOLDOFF_CYCLES, derived: 3*(FAST_FREQ/SLOW_FREQ)+4 (28 at defaults)

Ports:
- Clk  in  1  fast-domain clock
- Rst  in  1  synchronous, active-high reset
- Req_Valid  in  NUM_CH  per-channel sample strobe, one cycle per sample
- Req_Data  in  NUM_CH×WIDTH  per-channel sample, packed with channel c at [c*WIDTH +: WIDTH]
- Req_Ready  out  NUM_CH  channel slot can accept this cycle
- Xfer_Word  out  TAG_W+WIDTH  {tag, data} to the crossing's Data_In_Fast
- Xfer_Valid  out  1  one-cycle strobe to the crossing's Valid_In_Fast
- Overrun  out  NUM_CH  sticky per-channel overrun flags
- Ovr_Clr  in  1  clears all Overrun bits

## Operation
- Each channel has a one-entry slot with data and full bit. Req_Valid[c] with Req_Ready[c] high writes the slot and sets full.
- Req_Ready[c] = !full[c] | grant[c]. A slot being emptied this cycle accepts a new sample.
- FSM states:
  - IDLE → ISSUE: taken when any slot is full. Grant goes to the first full channel searching from rr_ptr upward, modulo NUM_CH. Xfer_Word is loaded with {c, slot[c]}, full[c] is cleared, and rr_ptr becomes (c+1) mod NUM_CH.
  - ISSUE: Xfer_Valid=1 for exactly one cycle. The hold-off counter is loaded with HOLDOFF_CYCLES-1. Next state is HOLDOFF.
  - HOLDOFF: the counter decrements; at 0 the FSM moves to IDLE. No grant occurs in ISSUE or HOLDOFF, while slots still accept samples.
- Xfer_Word holds its value until the next grant.
- Ovr_Clr has priority over a same-cycle overrun set. The bits are cleared.
- Reset values: state IDLE, rr_ptr 0, all full bits 0, Xfer_Valid 0, Xfer_Word 0, Overrun 0. Req_Ready is therefore all-ones after reset.
- Reset asserted mid-HOLDOFF aborts the window immediately. Pending slots are discarded.

## Timing
- Sample accepted at edge N → grant at edge N+1 (if IDLE) → Xfer_Valid high in the cycle after edge N+2.
- Back-to-back pending channels: Xfer_Valid pulses are spaced exactly HOLDOFF_CYCLES+2 cycles apart (30 at defaults).
- Worst-case latency for a channel is NUM_CH×(HOLDOFF_CYCLES+2)+2 cycles after acceptance.
- Requests are not rate-limited. Producers must average at most one sample per NUM_CH×(HOLDOFF_CYCLES+2) cycles.

## Configuration
Macro: CDC_SCHED_OVERRUN_EN
- Defined:
  - Req_Valid[c] while Req_Ready[c]=0 overwrites the slot with the newest sample; full stays 1.
  - Overrun[c] is set and stays set until Ovr_Clr.
- Undefined:
  - The new sample is dropped and the slot keeps the older one.
  - Overrun is tied to 0, and Ovr_Clr is ignored.

## Structure
- Package cdc_sched_pkg holds:
  - the state enum (IDLE, ISSUE, HOLDOFF);
  - functions computing TAG_W and HOLDOFF_CYCLES from the frequencies.
- Sub-module rr_arbiter: combinational NUM_CH-wide round-robin with req, ptr in, and one-hot grant plus index out. It is instantiated once.

## Test plan
- Single sample: Req_Valid[0] with 0x1234 at cycle 10 → Xfer_Valid in cycle 12 with Xfer_Word={0,0x1234}; no further pulse.
- Simultaneous requests: ch0=0xAAAA and ch1=0x5555 in the same cycle → {0,0xAAAA} is issued first, then {1,0x5555} exactly 30 cycles later.
- Fairness: both channels requesting continuously at a legal rate → issued tags alternate 0,1,0,1; rr_ptr wraps after ch1.
- Overrun:
  - Stimulus: ch0 writes 0x0001, then 0x0002 while that slot is full.
  - With CDC_SCHED_OVERRUN_EN: 0x0002 is issued and Overrun[0]=1 until Ovr_Clr.
  - Without it: 0x0001 is issued and Overrun=0.
- Grant plus refill in the same cycle: Req_Valid[0]=0xBEEF in the grant cycle of ch0 → 0xBEEF is accepted with no overrun and issued after hold-off.
- Reset mid-HOLDOFF with ch1 pending → Xfer_Valid stays 0, Req_Ready all-ones, and the next request issues with the normal 2-cycle latency.
